alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter: LAT, 1, ALU result latency in clock edges after operands are driven; legal range 1..4.
REQ-002 SHALL have ports, in order:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command
- cmd_opcode  input  4  ALU opcode
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- alu_opcode  output  4  opcode driven to the logical ALU
- alu_a  output  8  operand A to the ALU
- alu_b  output  8  operand B to the ALU
- alu_out  input  8  registered ALU result
- res_valid  output  1  result available
- res_ready  input  1  result consumer ready
- res_data  output  8  captured result
- res_opcode  output  4  opcode of the returned result
- res_err  output  1  illegal opcode flag

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD; all outputs registered.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid && cmd_ready at a rising edge.
REQ-005 On handshake, SHALL load alu_opcode/alu_a/alu_b from cmd_* and go to ISSUE.
REQ-006 alu_opcode/alu_a/alu_b SHALL hold their values until the next handshake.
REQ-007 ISSUE SHALL last one cycle, load a wait counter with LAT-1, and go to WAIT.
REQ-008 WAIT SHALL decrement the counter each cycle; at counter 0, SHALL capture alu_out into res_data, set res_opcode to alu_opcode, set res_valid=1, res_err=0, and go to HOLD.
REQ-009 With LAT=1, res_valid SHALL rise exactly 2 cycles after the handshake edge.
REQ-010 In HOLD, res_valid, res_data, res_opcode and res_err SHALL stay stable until res_valid && res_ready at an edge; then res_valid=0 and the FSM goes to IDLE.
REQ-011 A new command SHALL NOT be accepted in the same cycle a result is consumed; there is at most one command in flight.
REQ-012 Legal opcodes SHALL be 4'b0101..4'b1110; the codebase ALU returns 8'h00 for all others.
REQ-013 res_data SHALL be exactly the sampled alu_out; there is no arithmetic in this block.
REQ-014 cmd_valid seen outside IDLE SHALL be ignored; cmd_* SHALL NOT be sampled.

Reset
REQ-015 rst=1 SHALL immediately, without waiting for clk, force:
- state IDLE
- cmd_ready=0 while rst is asserted, 1 on the first cycle after release
- alu_opcode=4'b0000
- alu_a=alu_b=8'h00
- res_valid=0, res_data=8'h00, res_opcode=4'h0, res_err=0
- wait counter 0
REQ-016 Reset in ISSUE, WAIT or HOLD SHALL discard the in-flight command; no result is produced after release.

Configuration
REQ-017 Macro ALU_ISSUE_OPCHK_EN:
- Defined: a handshake with an illegal opcode SHALL NOT update alu_*; it SHALL go straight to HOLD with res_valid=1, res_data=8'h00, res_opcode=cmd_opcode, res_err=1 on the handshake edge (1-cycle latency).
- Undefined: illegal opcodes SHALL be issued like legal ones; res_err is constant 0.

Verification
REQ-018 LAT=1, opcode 4'b0101, a=8'h0F, b=8'hF0, res_ready=1 -> res_valid high 2 cycles after handshake, res_data=8'hFF, res_opcode=4'b0101.
REQ-019 Opcode 4'b1101, a=8'h80 -> res_data=8'hC0; opcode 4'b1110, a=8'hFF -> res_data=8'h00, res_err=0.
REQ-020 Opcode 4'b0110, a=8'h3C, b=8'h0F, res_ready held 0 for 5 cycles -> res_data=8'h0C stable, cmd_ready=0 throughout; cmd_valid pulsed meanwhile is not accepted.
REQ-021 Opcode 4'b0000:
- macro defined -> res_valid on the handshake edge, res_err=1, res_data=8'h00, alu_opcode unchanged;
- macro undefined -> res_valid after 2 cycles, res_err=0, res_data=8'h00.
REQ-022 LAT=3, opcode 4'b1000, a=8'hAA, b=8'hFF -> res_valid 4 cycles after handshake, res_data=8'h55.
REQ-023 rst asserted mid-clock-cycle during WAIT -> res_valid=0 and alu_opcode=0 before the next edge; after release, cmd_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one ALU command at a time to an external registered ALU. It waits
//   LAT+1 clock edges for the result, then returns the result with a
//   valid/ready handshake. Only one command is in flight at any time.
//
// Parameters
//   LAT        ALU result latency in clock edges after operands are driven (1..4)
//
// Optional feature (compile-time macro)
//   ALU_ISSUE_OPCHK_EN  illegal opcodes (outside 4'b0101..4'b1110) are not
//                       issued. They return at once with res_err=1 and
//                       res_data=8'h00.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_opcode/cmd_a/cmd_b         command payload
//   alu_opcode/alu_a/alu_b         operands held toward the ALU
//   alu_out                        registered ALU result
//   res_valid/res_ready            result handshake
//   res_data/res_opcode/res_err    returned result, its opcode, illegal-op flag
module alu_issue_ctrl #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_opcode,
    output logic       res_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

    state_t     state_r, state_s;
    logic [1:0] cnt_r, cnt_s;
    logic       hs_s;
    logic       cmd_ready_s;
    logic [3:0] alu_opcode_s;
    logic [7:0] alu_a_s, alu_b_s;
    logic       res_valid_s;
    logic [7:0] res_data_s;
    logic [3:0] res_opcode_s;
    logic       res_err_s;

    // Opcodes the ALU actually implements.
    function automatic logic op_legal(input logic [3:0] op);
        return (op >= 4'b0101) && (op <= 4'b1110);
    endfunction

    // Next-state and next-output logic. Outputs hold by default.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        cmd_ready_s  = 1'b0;
        alu_opcode_s = alu_opcode;
        alu_a_s      = alu_a;
        alu_b_s      = alu_b;
        res_valid_s  = res_valid;
        res_data_s   = res_data;
        res_opcode_s = res_opcode;
        res_err_s    = res_err;
        hs_s         = cmd_valid && cmd_ready;

        case (state_r)
            IDLE: begin
                if (hs_s) begin
`ifdef ALU_ISSUE_OPCHK_EN
                    if (!op_legal(cmd_opcode)) begin
                        // Illegal opcode: the ALU operands are left untouched.
                        state_s      = HOLD;
                        res_valid_s  = 1'b1;
                        res_data_s   = 8'h00;
                        res_opcode_s = cmd_opcode;
                        res_err_s    = 1'b1;
                    end else begin
                        state_s      = ISSUE;
                        alu_opcode_s = cmd_opcode;
                        alu_a_s      = cmd_a;
                        alu_b_s      = cmd_b;
                    end
`else
                    state_s      = ISSUE;
                    alu_opcode_s = cmd_opcode;
                    alu_a_s      = cmd_a;
                    alu_b_s      = cmd_b;
`endif
                end else begin
                    // Becomes 1 on the first edge after reset release.
                    cmd_ready_s = 1'b1;
                end
            end
            ISSUE: begin
                cnt_s   = CNT_LOAD;
                state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_s      = HOLD;
                    res_valid_s  = 1'b1;
                    res_data_s   = alu_out;
                    res_opcode_s = alu_opcode;
                    res_err_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    // cmd_ready was low on this edge, so no command can be
                    // accepted in the cycle the result is consumed.
                    state_s     = IDLE;
                    res_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 2'd0;
            cmd_ready  <= 1'b0;
            alu_opcode <= 4'b0000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            res_valid  <= 1'b0;
            res_data   <= 8'h00;
            res_opcode <= 4'h0;
            res_err    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cmd_ready  <= cmd_ready_s;
            alu_opcode <= alu_opcode_s;
            alu_a      <= alu_a_s;
            alu_b      <= alu_b_s;
            res_valid  <= res_valid_s;
            res_data   <= res_data_s;
            res_opcode <= res_opcode_s;
            res_err    <= res_err_s;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. It builds two instances, LAT=1 and LAT=3,
// each fed by a pipelined ALU model. Stimulus is shared. A per-instance
// transaction-level reference model predicts handshakes, result timing and
// result values at every falling edge.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a, cmd_b;
    logic       res_ready;

    logic       cmd_ready_w  [2];
    logic [3:0] alu_opcode_w [2];
    logic [7:0] alu_a_w      [2];
    logic [7:0] alu_b_w      [2];
    logic [7:0] alu_out_w    [2];
    logic       res_valid_w  [2];
    logic [7:0] res_data_w   [2];
    logic [3:0] res_opcode_w [2];
    logic       res_err_w    [2];

    int checks = 0;
    int errors = 0;
    int rr_mode = 1;

    always #5 clk = ~clk;

    // Behaviour of the ALU that this controller drives.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'b0101: return a + b;
            4'b0110: return a & b;
            4'b0111: return a | b;
            4'b1000: return a ^ b;
            4'b1001: return a - b;
            4'b1010: return ~a;
            4'b1011: return a << 1;
            4'b1100: return a >> 1;
            4'b1101: return {a[7], a[7:1]};
            4'b1110: return a + 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd14);
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    alu_issue_ctrl #(.LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[0]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode_w[0]), .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]),
        .alu_out(alu_out_w[0]),
        .res_valid(res_valid_w[0]), .res_ready(res_ready),
        .res_data(res_data_w[0]), .res_opcode(res_opcode_w[0]), .res_err(res_err_w[0])
    );

    alu_issue_ctrl #(.LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w[1]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode_w[1]), .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]),
        .alu_out(alu_out_w[1]),
        .res_valid(res_valid_w[1]), .res_ready(res_ready),
        .res_data(res_data_w[1]), .res_opcode(res_opcode_w[1]), .res_err(res_err_w[1])
    );

    // Registered ALU models: result appears LAT edges after operands change.
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    always @(posedge clk) pipe1 <= alu_f(alu_opcode_w[0], alu_a_w[0], alu_b_w[0]);
    always @(posedge clk) begin
        pipe3[0] <= alu_f(alu_opcode_w[1], alu_a_w[1], alu_b_w[1]);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign alu_out_w[0] = pipe1;
    assign alu_out_w[1] = pipe3[2];

    // res_ready driver: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model state, one transaction per instance.
    bit         busy [2], vis [2], hs_pend [2], cons_pend [2], after_rst [2], exp_ready [2];
    int         wait_c [2];
    logic [3:0] h_op [2], e_op [2], e_aop [2];
    logic [7:0] h_a [2], h_b [2], e_data [2], e_aa [2], e_ab [2];
    bit         e_err [2];

    // Reference model and output checks at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    busy[d] = 0; vis[d] = 0; hs_pend[d] = 0; cons_pend[d] = 0;
                    after_rst[d] = 1; exp_ready[d] = 0;
                    e_aop[d] = 4'h0; e_aa[d] = 8'h00; e_ab[d] = 8'h00;
                    chk($sformatf("rst_cmd_ready[%0d]", d), 32'(cmd_ready_w[d]), 32'd0);
                    chk($sformatf("rst_res_valid[%0d]", d), 32'(res_valid_w[d]), 32'd0);
                    chk($sformatf("rst_res_data[%0d]", d), 32'(res_data_w[d]), 32'd0);
                    chk($sformatf("rst_res_opcode[%0d]", d), 32'(res_opcode_w[d]), 32'd0);
                    chk($sformatf("rst_res_err[%0d]", d), 32'(res_err_w[d]), 32'd0);
                    chk($sformatf("rst_alu_ops[%0d]", d),
                        {12'd0, alu_opcode_w[d], alu_a_w[d], alu_b_w[d]}, 32'd0);
                end else begin
                    if (cons_pend[d]) begin
                        busy[d] = 0;
                        vis[d]  = 0;
                    end
                    if (hs_pend[d]) begin
                        busy[d] = 1;
                        if (OPCHK && !legal(h_op[d])) begin
                            vis[d] = 1; e_data[d] = 8'h00; e_op[d] = h_op[d]; e_err[d] = 1;
                        end else begin
                            e_aop[d] = h_op[d]; e_aa[d] = h_a[d]; e_ab[d] = h_b[d];
                            wait_c[d] = lat_of(d) + 1;
                            vis[d] = 0;
                            e_data[d] = alu_f(h_op[d], h_a[d], h_b[d]);
                            e_op[d] = h_op[d];
                            e_err[d] = 0;
                        end
                    end else if (busy[d] && !vis[d]) begin
                        wait_c[d]--;
                        if (wait_c[d] == 0) vis[d] = 1;
                    end
                    exp_ready[d] = !busy[d] && !after_rst[d];
                    after_rst[d] = 0;

                    chk($sformatf("cmd_ready[%0d]", d), 32'(cmd_ready_w[d]), 32'(exp_ready[d]));
                    chk($sformatf("res_valid[%0d]", d), 32'(res_valid_w[d]), 32'(vis[d]));
                    chk($sformatf("alu_ops[%0d]", d),
                        {12'd0, alu_opcode_w[d], alu_a_w[d], alu_b_w[d]},
                        {12'd0, e_aop[d], e_aa[d], e_ab[d]});
                    if (vis[d]) begin
                        chk($sformatf("res_data[%0d]", d), 32'(res_data_w[d]), 32'(e_data[d]));
                        chk($sformatf("res_opcode[%0d]", d), 32'(res_opcode_w[d]), 32'(e_op[d]));
                    end
                    if (vis[d] || !OPCHK)
                        chk($sformatf("res_err[%0d]", d), 32'(res_err_w[d]), vis[d] ? 32'(e_err[d]) : 32'd0);

                    hs_pend[d]   = cmd_valid && exp_ready[d];
                    h_op[d]      = cmd_opcode;
                    h_a[d]       = cmd_a;
                    h_b[d]       = cmd_b;
                    cons_pend[d] = vis[d] && res_ready;
                end
            end
        end
    end

    // Offer one command once both instances are ready; caller sits at posedge+2.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!(exp_ready[0] && exp_ready[1]) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("send_wait_bound", 32'(n < 100), 32'd1);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_opcode = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        send(4'b0101, 8'h0F, 8'hF0);
        send(4'b1101, 8'h80, 8'h00);
        send(4'b1110, 8'hFF, 8'h00);

        // Stalled consumer, with commands offered while busy.
        rr_mode = 0;
        send(4'b0110, 8'h3C, 8'h0F);
        for (int i = 0; i < 9; i++) begin
            cmd_valid = i[0];
            cmd_opcode = 4'b0111; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            @(posedge clk); #2;
        end
        cmd_valid = 1'b0;
        rr_mode = 1;

        send(4'b0000, 8'h12, 8'h34);
        send(4'b1000, 8'hAA, 8'hFF);

        // Reset in the middle of a cycle while the command is in flight.
        send(4'b0111, 8'h5A, 8'hA5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst_res_valid[%0d]", d), 32'(res_valid_w[d]), 32'd0);
            chk($sformatf("midrst_alu_opcode[%0d]", d), 32'(alu_opcode_w[d]), 32'd0);
            chk($sformatf("midrst_cmd_ready[%0d]", d), 32'(cmd_ready_w[d]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #2; end

        // Randomized traffic: each instance follows its own handshakes.
        rr_mode = 2;
        for (int i = 0; i < 2000; i++) begin
            cmd_valid  = ($urandom_range(0, 2) == 0);
            cmd_opcode = 4'($urandom);
            cmd_a      = 8'($urandom);
            cmd_b      = 8'($urandom);
            @(posedge clk); #2;
        end
        cmd_valid = 1'b0;
        rr_mode = 1;
        repeat (20) begin @(posedge clk); #2; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
